hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It detects load-use hazards and EX-stage taken branches, and handles a multi-cycle data-memory handshake. From these it drives the per-stage write-enable, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It works alongside the forwarding unit, covering the hazards that forwarding cannot resolve. It also owns a data-memory watchdog.

## Interface
Parameters:
- TIMEOUT, 16: maximum consecutive frozen cycles waiting on dmem_ready before the error state is entered; legal range 1..255.
- CNT_W, $clog2(TIMEOUT+1): width of the wait counter; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rt  in  5  load destination register
- if_id_rs, if_id_rt  in  5 each  source registers of the instruction in ID
- if_id_uses_rt  in  1  ID instruction reads rt as a source
- branch_taken  in  1  EX resolved a taken branch or jump
- dmem_req  in  1  MEM stage is accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- err_clr  in  1  leave the error state
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  register update enables
- if_id_flush, id_ex_flush  out  1 each  load a NOP/zero-control bubble
- mem_wb_bubble  out  1  MEM/WB captures a bubble
- pc_sel_branch  out  1  PC loads the branch target
- bus_err  out  1  watchdog error, level
- perf_ld_stall, perf_flush, perf_mem_wait  out  32 each  performance counters

## Operation
States and wait counter:
- States: RUN, DMEM_WAIT, ERR.
- Outputs are Mealy: a function of state and current inputs.
- Default outputs: all enables = 1; flush, bubble, pc_sel_branch and bus_err = 0.
- wait_cnt is CNT_W bits wide.

RUN, priority highest first:
1. Memory freeze, when dmem_req && !dmem_ready:
   - pc_write, if_id_write, id_ex_write and ex_mem_write = 0; mem_wb_bubble = 1.
   - Next state DMEM_WAIT; wait_cnt <= 1.
2. Branch, when branch_taken:
   - pc_sel_branch = 1, if_id_flush = 1, id_ex_flush = 1.
   - Any coincident load-use hazard is ignored.
3. Load-use:
   - Condition: id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt)).
   - Response: pc_write = 0, if_id_write = 0, id_ex_flush = 1.
   - Produces exactly one bubble; the hazard clears naturally the next cycle.

DMEM_WAIT:
- While !dmem_ready: freeze outputs as in RUN case 1; wait_cnt increments each cycle.
- If wait_cnt == TIMEOUT and still !dmem_ready, next state is ERR.
- When dmem_ready = 1: outputs are evaluated with the RUN rules for branch and load-use (the pipeline advances this cycle); next state RUN; wait_cnt <= 0.
- branch_taken is ignored while frozen, because EX is held and re-presents it afterwards.

ERR:
- Freeze outputs are held and bus_err = 1.
- err_clr = 1 sends the next state to RUN and clears wait_cnt. This takes priority over all other inputs in ERR.

Reset (rst_n = 0), asynchronous:
- State RUN, wait_cnt = 0, counters = 0.
- Outputs forced while held: all enables = 0, if_id_flush = id_ex_flush = mem_wb_bubble = 1, pc_sel_branch = 0, bus_err = 0.
- Asserting reset in DMEM_WAIT or ERR abandons the state immediately.

## Timing
- Hazard response has zero latency: controls are valid in the same cycle the inputs are presented. Callers register the inputs.
- State and counters update on the rising clk edge.
- Memory freeze:
  - Freeze holds from the first cycle dmem_req && !dmem_ready through the last !dmem_ready cycle.
  - The pipeline advances in the cycle dmem_ready = 1.
  - An access with dmem_ready = 1 in its first cycle causes no freeze.
- Watchdog:
  - Entry into ERR occurs at the edge following the TIMEOUT-th frozen cycle.
  - bus_err rises in the next cycle.
  - TIMEOUT = 1: ERR is entered after one frozen cycle.
- A dmem_ready arriving in the same cycle wait_cnt == TIMEOUT wins: next state RUN, not ERR.
- Back-to-back load-use hazards each produce one bubble; no cycles are merged.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - perf_ld_stall counts load-use bubble cycles.
  - perf_flush counts branch-flush cycles.
  - perf_mem_wait counts frozen cycles in RUN, DMEM_WAIT and ERR.
  - All counters saturate at 32'hFFFF_FFFF and are cleared only by reset.
- Undefined: no counter logic is built, and the three perf outputs are tied to 32'h0. The port list is unchanged.

## Test plan
- Load-use: id_ex_mem_read = 1, id_ex_rt = 5, if_id_rs = 5 for one cycle -> pc_write = 0, if_id_write = 0, id_ex_flush = 1 that cycle only; perf_ld_stall = 1. Repeat with id_ex_rt = 0 -> no stall.
- Branch plus hazard: branch_taken = 1 with a load-use match in the same cycle -> pc_sel_branch = 1, if_id_flush = id_ex_flush = 1, pc_write = 1; perf_flush = 1, perf_ld_stall = 0.
- Memory wait: dmem_req = 1, dmem_ready low for 3 cycles then high -> 3 frozen cycles with mem_wb_bubble = 1, advance on the 4th cycle, state back to RUN; perf_mem_wait = 3.
- Watchdog: TIMEOUT = 4, dmem_ready held 0 -> ERR after 4 frozen cycles and bus_err = 1 from cycle 5. err_clr pulse -> RUN and bus_err = 0 next cycle.
- Boundary: dmem_ready rises in the cycle wait_cnt == TIMEOUT -> RUN, bus_err stays 0.
- Reset mid-wait: assert rst_n = 0 in DMEM_WAIT -> outputs immediately forced to their reset values. Release -> RUN with all counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/branch/dmem-freeze sequencing with a dmem watchdog.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int  TIMEOUT = 16,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rt,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rt,
    input  logic        if_id_uses_rt,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        err_clr,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_bubble,
    output logic        pc_sel_branch,
    output logic        bus_err,
    output logic [31:0] perf_ld_stall,
    output logic [31:0] perf_flush,
    output logic [31:0] perf_mem_wait
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        ERR       = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             load_use;
    logic             frz;
    logic             adv;

    assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) ||
                       (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    // Next state; wait_cnt_d counts frozen cycles including the current one
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        frz        = 1'b0;
        adv        = 1'b0;
        unique case (state_q)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    frz        = 1'b1;
                    wait_cnt_d = CNT_W'(1);
                    state_d    = (TIMEOUT == 1) ? ERR : DMEM_WAIT;
                end else begin
                    adv = 1'b1;
                end
            end
            DMEM_WAIT: begin
                if (!dmem_ready) begin
                    frz        = 1'b1;
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (wait_cnt_d == CNT_W'(TIMEOUT)) begin
                        state_d = ERR;
                    end
                end else begin
                    adv        = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERR: begin
                frz = 1'b1;
                if (err_clr) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Mealy stage controls; reset holds every stage in a bubble
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        pc_sel_branch = 1'b0;
        bus_err       = 1'b0;
        if (!rst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (frz) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
            bus_err       = (state_q == ERR);
        end else if (adv && branch_taken) begin
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end else if (adv && load_use) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_flush   = 1'b1;
        end
    end

    // State and watchdog counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] ld_cnt_q, fl_cnt_q, mw_cnt_q;

    // Saturating event counters, classified from the issued controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_q <= '0;
            fl_cnt_q <= '0;
            mw_cnt_q <= '0;
        end else begin
            if (id_ex_flush && !if_id_flush && ld_cnt_q != '1)
                ld_cnt_q <= ld_cnt_q + 32'd1;
            if (pc_sel_branch && fl_cnt_q != '1)
                fl_cnt_q <= fl_cnt_q + 32'd1;
            if (mem_wb_bubble && mw_cnt_q != '1)
                mw_cnt_q <= mw_cnt_q + 32'd1;
        end
    end

    assign perf_ld_stall = ld_cnt_q;
    assign perf_flush    = fl_cnt_q;
    assign perf_mem_wait = mw_cnt_q;
`else
    assign perf_ld_stall = 32'h0;
    assign perf_flush    = 32'h0;
    assign perf_mem_wait = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl with TIMEOUT = 4.
// Perf expectations follow HAZARD_PERF_CNT_EN (zero when undefined).
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic        if_id_uses_rt;
    logic        branch_taken;
    logic        dmem_req;
    logic        dmem_ready;
    logic        err_clr;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        ex_mem_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_bubble;
    logic        pc_sel_branch;
    logic        bus_err;
    logic [31:0] perf_ld_stall;
    logic [31:0] perf_flush;
    logic [31:0] perf_mem_wait;

    logic [8:0]  ctl;
    int          checks = 0;
    int          errors = 0;
    int          e_ld = 0;
    int          e_fl = 0;
    int          e_mw = 0;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_w, ifid_w, idex_w, exmem_w, ifid_fl, idex_fl, bubble, br_sel, err}
    localparam logic [8:0] V_IDLE = 9'b1111_0000_0;
    localparam logic [8:0] V_LU   = 9'b0011_0100_0;
    localparam logic [8:0] V_BR   = 9'b1111_1101_0;
    localparam logic [8:0] V_FRZ  = 9'b0000_0010_0;
    localparam logic [8:0] V_ERR  = 9'b0000_0010_1;
    localparam logic [8:0] V_RST  = 9'b0000_1110_0;

    hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_ex_mem_read(id_ex_mem_read),
        .id_ex_rt      (id_ex_rt),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .if_id_uses_rt (if_id_uses_rt),
        .branch_taken  (branch_taken),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .err_clr       (err_clr),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .id_ex_write   (id_ex_write),
        .ex_mem_write  (ex_mem_write),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .mem_wb_bubble (mem_wb_bubble),
        .pc_sel_branch (pc_sel_branch),
        .bus_err       (bus_err),
        .perf_ld_stall (perf_ld_stall),
        .perf_flush    (perf_flush),
        .perf_mem_wait (perf_mem_wait)
    );

    assign ctl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                  if_id_flush, id_ex_flush, mem_wb_bubble,
                  pc_sel_branch, bus_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pexp(input int v);
        return PERF ? 32'(v) : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_perf(input string tag);
        chk({tag, "_ld"}, perf_ld_stall, pexp(e_ld));
        chk({tag, "_fl"}, perf_flush, pexp(e_fl));
        chk({tag, "_mw"}, perf_mem_wait, pexp(e_mw));
    endtask

    task automatic idle_in();
        id_ex_mem_read = 1'b0;
        id_ex_rt       = 5'd0;
        if_id_rs       = 5'd0;
        if_id_rt       = 5'd0;
        if_id_uses_rt  = 1'b0;
        branch_taken   = 1'b0;
        dmem_req       = 1'b0;
        dmem_ready     = 1'b0;
        err_clr        = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_in();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ctl", 32'(ctl), 32'(V_RST));
        chk_perf("rst");
        @(negedge clk); rst_n = 1'b1;
        #2 chk("idle", 32'(ctl), 32'(V_IDLE));

        // load-use via rs
        @(negedge clk);
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
        #2 chk("lu_rs", 32'(ctl), 32'(V_LU));
        e_ld = 1;
        @(negedge clk); idle_in();
        #2 chk("lu_clear", 32'(ctl), 32'(V_IDLE));
        chk_perf("lu1");

        // r0 destination never stalls
        @(negedge clk);
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
        if_id_uses_rt = 1'b1;
        #2 chk("lu_r0", 32'(ctl), 32'(V_IDLE));

        // load-use via rt, gated by uses_rt
        @(negedge clk);
        id_ex_rt = 5'd7; if_id_rs = 5'd3; if_id_rt = 5'd7;
        #2 chk("lu_rt", 32'(ctl), 32'(V_LU));
        e_ld = 2;
        @(negedge clk); if_id_uses_rt = 1'b0;
        #2 chk("lu_rt_unused", 32'(ctl), 32'(V_IDLE));

        // back-to-back hazards, one bubble each
        @(negedge clk); if_id_rs = 5'd7;
        #2 chk("b2b_1", 32'(ctl), 32'(V_LU));
        @(negedge clk); id_ex_rt = 5'd9; if_id_rs = 5'd9;
        #2 chk("b2b_2", 32'(ctl), 32'(V_LU));
        e_ld = 4;
        @(negedge clk); idle_in();
        #2 chk_perf("b2b");

        // branch overrides a coincident load-use
        @(negedge clk);
        branch_taken = 1'b1;
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
        #2 chk("br_haz", 32'(ctl), 32'(V_BR));
        e_fl = 1;
        @(negedge clk); idle_in();
        #2 chk_perf("br");

        // memory wait: three frozen cycles then advance
        @(negedge clk); dmem_req = 1'b1;
        #2 chk("mw_c1", 32'(ctl), 32'(V_FRZ));
        @(negedge clk); branch_taken = 1'b1;
        #2 chk("mw_c2_br", 32'(ctl), 32'(V_FRZ));
        @(negedge clk); branch_taken = 1'b0;
        #2 chk("mw_c3", 32'(ctl), 32'(V_FRZ));
        @(negedge clk); dmem_ready = 1'b1;
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
        #2 chk("mw_adv_lu", 32'(ctl), 32'(V_LU));
        e_ld = 5; e_mw = 3;
        @(negedge clk); idle_in();
        #2 chk("mw_run", 32'(ctl), 32'(V_IDLE));
        chk_perf("mw");

        // ready in the first cycle: no freeze
        @(negedge clk); dmem_req = 1'b1; dmem_ready = 1'b1;
        #2 chk("mw_fast", 32'(ctl), 32'(V_IDLE));
        @(negedge clk); idle_in();
        #2 chk_perf("mw_fast");

        // reset clears counters
        rst_n = 1'b0;
        #1 chk("rst2_ctl", 32'(ctl), 32'(V_RST));
        @(negedge clk); rst_n = 1'b1;
        e_ld = 0; e_fl = 0; e_mw = 0;
        #2 chk_perf("rst2");

        // watchdog: ERR after 4 frozen cycles
        @(negedge clk); dmem_req = 1'b1;
        #2 chk("wd_f1", 32'(ctl), 32'(V_FRZ));
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            #2 chk($sformatf("wd_f%0d", i), 32'(ctl), 32'(V_FRZ));
        end
        @(negedge clk);
        #2 chk("wd_err", 32'(ctl), 32'(V_ERR));
        @(negedge clk); err_clr = 1'b1;
        #2 chk("wd_clr", 32'(ctl), 32'(V_ERR));
        @(negedge clk); idle_in();
        #2 chk("wd_run", 32'(ctl), 32'(V_IDLE));
        e_mw = 6;
        chk_perf("wd");

        // ready on the last cycle before the watchdog trips
        @(negedge clk); dmem_req = 1'b1;
        #2 chk("to_f1", 32'(ctl), 32'(V_FRZ));
        @(negedge clk);
        #2 chk("to_f2", 32'(ctl), 32'(V_FRZ));
        @(negedge clk);
        #2 chk("to_f3", 32'(ctl), 32'(V_FRZ));
        @(negedge clk); dmem_ready = 1'b1;
        #2 chk("to_rdy", 32'(ctl), 32'(V_IDLE));
        @(negedge clk); idle_in();
        #2 chk("to_run", 32'(ctl), 32'(V_IDLE));
        e_mw = 9;
        chk_perf("to");

        // reset while waiting on memory
        @(negedge clk); dmem_req = 1'b1;
        #2 chk("rw_f1", 32'(ctl), 32'(V_FRZ));
        @(negedge clk);
        #2 chk("rw_f2", 32'(ctl), 32'(V_FRZ));
        rst_n = 1'b0;
        #1 chk("rw_rst_ctl", 32'(ctl), 32'(V_RST));
        e_ld = 0; e_fl = 0; e_mw = 0;
        chk_perf("rw_rst");
        @(negedge clk); rst_n = 1'b1; idle_in();
        #2 chk("rw_run", 32'(ctl), 32'(V_IDLE));
        chk_perf("rw_rel");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
